leaf_downlink_merger: RTL and testbench

- Ejection stage directly downstream of the spine router leaf-facing outputs (spineN1..spineN4 out_data/out_valid) inside one leaf of a group.
- Spine outputs carry no backpressure, so each uplink gets its own absorbing FIFO.
- A round-robin arbiter merges the FIFOs into one valid/ready local stream toward the GPU node interface.
- Flits for another group, and flits that arrive when their FIFO is full, are dropped and counted.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/leaf_downlink_merger_if.sv | 33 +++
 rtl/flit_fifo.sv | 63 ++++++
 rtl/leaf_downlink_merger.sv | 135 +++++++++++++
 tb/tb_leaf_downlink_merger.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the leaf ejection path.
// Flit layout: [15:12] dest group, [11:10] dest node, [9:0] payload.
// Also holds default flit width / FIFO depth and group ID constants.
package noc_pkg;

  localparam int unsigned DEST_GRP_MSB  = 15;
  localparam int unsigned DEST_GRP_LSB  = 12;
  localparam int unsigned DEST_NODE_MSB = 11;
  localparam int unsigned DEST_NODE_LSB = 10;
  localparam int unsigned GRP_W         = DEST_GRP_MSB - DEST_GRP_LSB + 1;

  localparam int unsigned DEF_DWIDTH     = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  localparam logic [GRP_W-1:0] GROUP_ID_DEFAULT = 4'b0100;

  function automatic logic [GRP_W-1:0] flit_group(input logic [DEF_DWIDTH-1:0] flit);
    return flit[DEST_GRP_MSB:DEST_GRP_LSB];
  endfunction

endpackage

// File: rtl/leaf_downlink_merger_if.sv
// Bus bundle for leaf_downlink_merger.
//   up_data/up_valid  : per-uplink flits from spine routers (no backpressure)
//   local_out_*       : merged valid/ready stream toward the node
//   ovf_drop_cnt, misroute_cnt, fifo_nonempty : status/debug
// slave = merger side, master = spine/node side.
interface leaf_downlink_merger_if
  import noc_pkg::*;
#(
  parameter int unsigned NUM_UPLINKS = 4,
  parameter int unsigned DWIDTH      = DEF_DWIDTH,
  parameter int unsigned CNT_W       = 8
);

  logic [NUM_UPLINKS*DWIDTH-1:0] up_data;
  logic [NUM_UPLINKS-1:0]        up_valid;
  logic [DWIDTH-1:0]             local_out_data;
  logic                          local_out_valid;
  logic                          local_out_ready;
  logic [CNT_W-1:0]              ovf_drop_cnt;
  logic [CNT_W-1:0]              misroute_cnt;
  logic [NUM_UPLINKS-1:0]        fifo_nonempty;

  modport slave (
    input  up_data, up_valid, local_out_ready,
    output local_out_data, local_out_valid, ovf_drop_cnt, misroute_cnt, fifo_nonempty
  );

  modport master (
    output up_data, up_valid, local_out_ready,
    input  local_out_data, local_out_valid, ovf_drop_cnt, misroute_cnt, fifo_nonempty
  );

endinterface

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO, async active-low reset.
//   push/wdata : write (caller guarantees not full, or popped same cycle)
//   pop/head   : read head (caller guarantees not empty)
//   count/full/empty : occupancy status
module flit_fifo
  import noc_pkg::*;
#(
  parameter  int unsigned DWIDTH     = DEF_DWIDTH,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned AW         = $clog2(FIFO_DEPTH),
  localparam int unsigned CW         = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/leaf_downlink_merger.sv
// Leaf ejection stage: one absorbing FIFO per spine uplink, round-robin merge
// into a single registered valid/ready stream toward the node.
//   clk, reset (async, active-low)
//   bus.slave : uplink flits in, merged flit out, drop counters, FIFO status
// Flits for another group, or arriving at a full FIFO, are dropped and counted
// in saturating counters.
module leaf_downlink_merger
  import noc_pkg::*;
#(
  parameter logic [GRP_W-1:0] GROUP_ID    = GROUP_ID_DEFAULT,
  parameter int unsigned      NUM_UPLINKS = 4,
  parameter int unsigned      DWIDTH      = DEF_DWIDTH,
  parameter int unsigned      FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned      CNT_W       = 8
) (
  input logic                   clk,
  input logic                   reset,
  leaf_downlink_merger_if.slave bus
);

  localparam int unsigned RR_W = (NUM_UPLINKS > 1) ? $clog2(NUM_UPLINKS) : 1;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);

  logic [NUM_UPLINKS-1:0] push, pop, full, empty, nonempty;
  logic [DWIDTH-1:0]      head  [NUM_UPLINKS];
  logic [CW-1:0]          count [NUM_UPLINKS];

  logic [RR_W-1:0]   rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d, mis_q, mis_d;

  logic            load, grant_vld;
  logic [RR_W-1:0] grant_idx;
  logic [CNT_W:0]  mis_n, ovf_n, mis_sum, ovf_sum;

  for (genvar g = 0; g < NUM_UPLINKS; g++) begin : g_fifo
    flit_fifo #(
      .DWIDTH    (DWIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst_n(reset),
      .push (push[g]),
      .pop  (pop[g]),
      .wdata(bus.up_data[g*DWIDTH +: DWIDTH]),
      .head (head[g]),
      .count(count[g]),
      .full (full[g]),
      .empty(empty[g])
    );
    assign nonempty[g] = (count[g] != '0);
  end

  assign load = !out_valid_q || bus.local_out_ready;

  // Round-robin scan starting at rr_q, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_UPLINKS; i++) begin
      idx = (32'(rr_q) + i) % NUM_UPLINKS;
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'(idx);
      end
    end
  end

  assign pop = (load && grant_vld) ? (NUM_UPLINKS'(1) << grant_idx) : '0;

  // A full FIFO still accepts when its head is popped this cycle; the pop
  // frees the slot the push writes into.
  always_comb begin
    push  = '0;
    mis_n = '0;
    ovf_n = '0;
    for (int unsigned i = 0; i < NUM_UPLINKS; i++) begin
      if (bus.up_valid[i]) begin
        if (flit_group(bus.up_data[i*DWIDTH +: DEF_DWIDTH]) != GROUP_ID)
          mis_n = mis_n + CNT_ONE;
        else if (!full[i] || pop[i])
          push[i] = 1'b1;
        else
          ovf_n = ovf_n + CNT_ONE;
      end
    end
  end

  always_comb begin
    mis_sum = {1'b0, mis_q} + mis_n;
    ovf_sum = {1'b0, ovf_q} + ovf_n;
    mis_d   = mis_sum[CNT_W] ? '1 : mis_sum[CNT_W-1:0];
    ovf_d   = ovf_sum[CNT_W] ? '1 : ovf_sum[CNT_W-1:0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_d        = rr_q;
    if (load) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = head[grant_idx];
        rr_d       = RR_W'((32'(grant_idx) + 32'd1) % NUM_UPLINKS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= '0;
      mis_q       <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      mis_q       <= mis_d;
    end
  end

  assign bus.local_out_valid = out_valid_q;
  assign bus.local_out_data  = out_data_q;
  assign bus.ovf_drop_cnt    = ovf_q;
  assign bus.misroute_cnt    = mis_q;
  assign bus.fifo_nonempty   = nonempty;

endmodule

// File: tb/tb_leaf_downlink_merger.sv
// Directed self-checking bench for leaf_downlink_merger.
module tb_leaf_downlink_merger;
  import noc_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  leaf_downlink_merger_if #(.NUM_UPLINKS(4), .DWIDTH(16), .CNT_W(8)) bus ();

  leaf_downlink_merger #(
    .GROUP_ID   (4'b0100),
    .NUM_UPLINKS(4),
    .DWIDTH     (16),
    .FIFO_DEPTH (8),
    .CNT_W      (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
    bus.up_valid = v;
    bus.up_data  = {d3, d2, d1, d0};
  endtask

  task automatic idle;
    drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset;
    idle;
    bus.local_out_ready = 1'b1;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
  endtask

  function automatic logic [31:0] vd(input logic v, input logic [15:0] d);
    return {15'd0, v, d};
  endfunction

  initial begin
    idle;
    bus.local_out_ready = 1'b1;
    reset = 1'b0;
    tick;
    tick;
    chk("rst_valid", 32'(bus.local_out_valid), 32'd0);
    chk("rst_data",  32'(bus.local_out_data),  32'd0);
    chk("rst_ovf",   32'(bus.ovf_drop_cnt),    32'd0);
    chk("rst_mis",   32'(bus.misroute_cnt),    32'd0);
    chk("rst_ne",    32'(bus.fifo_nonempty),   32'd0);
    reset = 1'b1;
    tick;

    // Single flit, two-cycle latency, one-cycle pulse.
    drive(4'b0100, 16'h0, 16'h0, 16'h4A55, 16'h0);
    tick;
    idle;
    chk("t1_wait", 32'(bus.local_out_valid), 32'd0);
    chk("t1_ne",   32'(bus.fifo_nonempty),   32'h4);
    tick;
    chk("t1_out",  vd(bus.local_out_valid, bus.local_out_data), vd(1'b1, 16'h4A55));
    tick;
    chk("t1_once", 32'(bus.local_out_valid), 32'd0);
    chk("t1_ovf",  32'(bus.ovf_drop_cnt),    32'd0);
    chk("t1_mis",  32'(bus.misroute_cnt),    32'd0);

    // All four uplinks at once from pointer 0.
    do_reset;
    drive(4'b1111, 16'h4001, 16'h4002, 16'h4003, 16'h4004);
    tick;
    idle;
    chk("t2_ne", 32'(bus.fifo_nonempty), 32'hF);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t2_out", vd(bus.local_out_valid, bus.local_out_data), vd(1'b1, 16'(16'h4001 + k)));
    end
    tick;
    chk("t2_idle", 32'(bus.local_out_valid), 32'd0);
    // Pointer should be back at 0: uplink 0 must win over uplink 3.
    drive(4'b1001, 16'h4010, 16'h0, 16'h0, 16'h4013);
    tick;
    idle;
    tick;
    chk("t2_rr0", vd(bus.local_out_valid, bus.local_out_data), vd(1'b1, 16'h4010));
    tick;
    chk("t2_rr3", vd(bus.local_out_valid, bus.local_out_data), vd(1'b1, 16'h4013));
    tick;
    chk("t2_rr_idle", 32'(bus.local_out_valid), 32'd0);

    // Backpressure: 10 flits, 1 in register, 8 buffered, 1 dropped.
    do_reset;
    bus.local_out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(4'b0001, 16'(16'h4100 + k), 16'h0, 16'h0, 16'h0);
      tick;
    end
    idle;
    chk("t3_head", vd(bus.local_out_valid, bus.local_out_data), vd(1'b1, 16'h4100));
    chk("t3_ovf",  32'(bus.ovf_drop_cnt),  32'd1);
    chk("t3_ne",   32'(bus.fifo_nonempty), 32'h1);
    repeat (3) tick;
    chk("t3_hold", vd(bus.local_out_valid, bus.local_out_data), vd(1'b1, 16'h4100));
    bus.local_out_ready = 1'b1;
    for (int k = 1; k < 9; k++) begin
      tick;
      chk("t3_drain", vd(bus.local_out_valid, bus.local_out_data), vd(1'b1, 16'(16'h4100 + k)));
    end
    tick;
    chk("t3_empty",    32'(bus.local_out_valid), 32'd0);
    chk("t3_empty_ne", 32'(bus.fifo_nonempty),   32'd0);

    // Misrouted flits on uplinks 1 and 3.
    drive(4'b1010, 16'h0, 16'h5123, 16'h0, 16'h5123);
    tick;
    idle;
    chk("t4_mis", 32'(bus.misroute_cnt),  32'd2);
    chk("t4_ne",  32'(bus.fifo_nonempty), 32'd0);
    chk("t4_ovf", 32'(bus.ovf_drop_cnt),  32'd1);
    tick;
    tick;
    chk("t4_noout", 32'(bus.local_out_valid), 32'd0);

    // Overflow counter saturation: after n sends with ready low, drops = n-9.
    do_reset;
    bus.local_out_ready = 1'b0;
    drive(4'b0001, 16'h4200, 16'h0, 16'h0, 16'h0);
    repeat (263) tick;
    chk("t5_254", 32'(bus.ovf_drop_cnt), 32'd254);
    tick;
    chk("t5_255", 32'(bus.ovf_drop_cnt), 32'd255);
    repeat (45) tick;
    chk("t5_sat", 32'(bus.ovf_drop_cnt), 32'd255);
    idle;

    // Async reset mid-drain with 3 flits queued.
    do_reset;
    bus.local_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(4'b0010, 16'h0, 16'(16'h4300 + k), 16'h0, 16'h0);
      tick;
    end
    drive(4'b0001, 16'h7000, 16'h0, 16'h0, 16'h0);
    tick;
    idle;
    chk("t6_pre_out", vd(bus.local_out_valid, bus.local_out_data), vd(1'b1, 16'h4300));
    chk("t6_pre_ne",  32'(bus.fifo_nonempty), 32'h2);
    chk("t6_pre_mis", 32'(bus.misroute_cnt),  32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.local_out_valid), 32'd0);
    chk("t6_data",  32'(bus.local_out_data),  32'd0);
    chk("t6_ne",    32'(bus.fifo_nonempty),   32'd0);
    chk("t6_mis",   32'(bus.misroute_cnt),    32'd0);
    chk("t6_ovf",   32'(bus.ovf_drop_cnt),    32'd0);
    tick;
    reset = 1'b1;
    bus.local_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("t6_stale", 32'(bus.local_out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
